// File: rtl/mux421_pkg.sv
// Shared types and constants for the 4:1 mux round-robin arbiter.
package mux421_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SEL_W        = 2;
  localparam int CNT_W        = 8;
  localparam int DEF_MAX_HOLD = 8;

  function automatic logic [3:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping 3->0.
module rr_pick4
  import mux421_pkg::*;
(
  input  logic [3:0]       i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  logic [SEL_W-1:0] w_idx1;
  logic [SEL_W-1:0] w_idx2;
  logic [SEL_W-1:0] w_idx3;

  assign w_idx1 = i_ptr + 2'd1;
  assign w_idx2 = i_ptr + 2'd2;
  assign w_idx3 = i_ptr + 2'd3;

  assign o_any    = |i_req;
  assign o_winner = i_req[i_ptr]  ? i_ptr  :
                    i_req[w_idx1] ? w_idx1 :
                    i_req[w_idx2] ? w_idx2 : w_idx3;

endmodule

// File: rtl/mux421_arb.sv
// Round-robin arbiter driving a 4:1 mux select, with bounded hold and a one-cycle switch gap.
module mux421_arb
  import mux421_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [3:0]       Req,
  input  logic             Done,
  output logic [3:0]       Gnt,
  output logic [SEL_W-1:0] Sel,
  output logic             Valid
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_gnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_valid_nxt;
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_exit;

  rr_pick4 u_pick (
    .i_req    (Req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // The current owner is whatever Sel points at while BUSY.
  assign w_exit = Done | ~Req[r_sel] | (r_cnt == HOLD_LIM);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = onehot4(w_winner);
          w_sel_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 8'd1;
        end else begin
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (w_exit) begin
          w_state_nxt = GAP;
          w_ptr_nxt   = r_sel + 2'd1;
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign Gnt   = r_gnt;
  assign Sel   = r_sel;
  assign Valid = r_valid;

endmodule

// File: tb/tb_mux421_arb.sv
// Directed scoreboard bench for mux421_arb: expected outputs queued at drive time, checked after each edge.
module tb_mux421_arb;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  logic       Clk;
  logic       Reset_n;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Valid;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  mux421_arb #(.MAX_HOLD(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Req     (Req),
    .Done    (Done),
    .Gnt     (Gnt),
    .Sel     (Sel),
    .Valid   (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_now(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev);
    exp_t got;
    exp_t e;
    got = {Gnt, Sel, Valid};
    e   = {eg, es, ev};
    n_cmp++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s: observed gnt=%b sel=%0d valid=%b expected gnt=%b sel=%0d valid=%b",
             tag, got.gnt, got.sel, got.valid, e.gnt, e.sel, e.valid);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic done, input logic [3:0] eg,
                      input logic [1:0] es, input logic ev, input string tag);
    exp_t e;
    Req  = req;
    Done = done;
    sb_q.push_back({eg, es, ev});
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check_now(tag, e.gnt, e.sel, e.valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         order[5];
    logic [1:0] s;
    n_cmp   = 0;
    n_err   = 0;
    Req     = 4'b0000;
    Done    = 1'b0;
    Reset_n = 1'b0;
    order   = '{0, 1, 2, 3, 0};

    @(posedge Clk);
    @(posedge Clk);
    #1;
    check_now("reset_state", 4'b0000, 2'd0, 1'b0);
    Reset_n = 1'b1;

    // Single requester on input 2 with a Done pulse on its third BUSY cycle.
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_grant");
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_busy2");
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_busy3");
    step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, "single_gap");
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "single_idle");
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "idle_hold");

    // Pointer now 3: 1001 must pick 3, non-owner churn ignored, then 0.
    step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, "wrap_gnt3");
    step(4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1, "nonowner_ign");
    step(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, "wrap_gap");
    step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, "gap_ignores");
    step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, "wrap_gnt0");
    step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "wrap0_gap");
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "wrap0_idle");

    // Owner 2 granted, then reset pulled between edges.
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "pre_rst_gnt2");
    #2;
    Reset_n = 1'b0;
    #1;
    check_now("rst_mid_busy", 4'b0000, 2'd0, 1'b0);
    @(posedge Clk);
    #1;
    check_now("rst_held", 4'b0000, 2'd0, 1'b0);
    Reset_n = 1'b1;

    // All four requesting, Done on every second BUSY cycle: order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      s = 2'(order[k]);
      step(4'b1111, 1'b0, 4'b0001 << s, s, 1'b1, "fair_gnt");
      step(4'b1111, 1'b0, 4'b0001 << s, s, 1'b1, "fair_busy2");
      step(4'b1111, 1'b1, 4'b0000, s, 1'b0, "fair_gap");
      step(4'b1111, 1'b0, 4'b0000, s, 1'b0, "fair_idle");
    end

    // Pointer 1, only input 0 requesting: eight-cycle timeout then re-grant.
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "to_gnt");
    for (int k = 0; k < 7; k++) begin
      step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "to_hold");
    end
    step(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "to_gap");
    step(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "to_idle");
    step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "to_regrant");

    // Hold to the limit, then Done, owner drop and timeout all at once.
    for (int k = 0; k < 7; k++) begin
      step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "sim_hold");
    end
    step(4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0, "sim_gap");
    step(4'b1110, 1'b0, 4'b0000, 2'd0, 1'b0, "sim_idle");
    step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, "sim_ptr_once");
    step(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, "sim_end_gap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
